// File: rtl/s2qed_fetch_sync_pkg.sv
// Shared S2QED definitions: fetch-synchroniser state encoding and the default
// bus widths that the equivalence checker also uses.
package s2qed_pkg;

    localparam int unsigned S2QED_DATA_W = 32;
    localparam int unsigned S2QED_ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PEER,
        ST_FETCH,
        ST_RESP,
        ST_ERROR
    } s2qed_fetch_state_t;

endpackage

// File: rtl/s2qed_fetch_sync_if.sv
// Fetch-side bundle between the shared instruction source, the two cores'
// fetch ports and the lockstep synchroniser (slave = synchroniser side).
interface s2qed_fetch_sync_if
    import s2qed_pkg::*;
#(
    parameter int unsigned DATA_W = S2QED_DATA_W,
    parameter int unsigned ADDR_W = S2QED_ADDR_W
) ();

    logic [DATA_W-1:0] inst_in;
    logic              inst_in_valid;
    logic              inst_in_ready;

    logic              cpu0_req;
    logic [ADDR_W-1:0] cpu0_addr;
    logic              cpu0_ack;
    logic [DATA_W-1:0] cpu0_data;

    logic              cpu1_req;
    logic [ADDR_W-1:0] cpu1_addr;
    logic              cpu1_ack;
    logic [DATA_W-1:0] cpu1_data;

    modport slave (
        input  inst_in, inst_in_valid,
        input  cpu0_req, cpu0_addr, cpu1_req, cpu1_addr,
        output inst_in_ready,
        output cpu0_ack, cpu0_data, cpu1_ack, cpu1_data
    );

    modport master (
        output inst_in, inst_in_valid,
        output cpu0_req, cpu0_addr, cpu1_req, cpu1_addr,
        input  inst_in_ready,
        input  cpu0_ack, cpu0_data, cpu1_ack, cpu1_data
    );

endinterface

// File: rtl/s2qed_fetch_sync_wait_timer.sv
// Peer-wait timer: clearable up-counter whose terminal flag marks the cycle on
// which the count would reach TIMEOUT.
module s2qed_wait_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Flag on the counting cycle itself so the caller can leave on that edge.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/s2qed_fetch_sync.sv
// Lockstep fetch synchroniser: both cores receive the same word per fetch.
// Optional peer-wait timeout enabled by S2QED_FETCH_SYNC_TIMEOUT_EN.
module s2qed_fetch_sync
    import s2qed_pkg::*;
#(
    parameter int unsigned DATA_W  = S2QED_DATA_W,
    parameter int unsigned ADDR_W  = S2QED_ADDR_W,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    s2qed_fetch_sync_if.slave    bus,
    output logic [DATA_W-1:0]    sync_inst,
    output logic [CNT_W-1:0]     fetch_cnt,
    output logic                 addr_mismatch,
    output logic                 timeout_err
);

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("s2qed_fetch_sync: TIMEOUT must be within 1..65535");
    end

    s2qed_fetch_state_t state_q, state_d;
    logic [DATA_W-1:0]  inst_q;
    logic               waiter_q;
    logic               peer_req;
    logic               both_req;
    logic               cmp_now;
    logic               addr_ne;

    assign both_req = bus.cpu0_req && bus.cpu1_req;
    // waiter_q = 1 means cpu1 arrived first, so the peer is cpu0.
    assign peer_req = waiter_q ? bus.cpu0_req : bus.cpu1_req;
    assign addr_ne  = (bus.cpu0_addr != bus.cpu1_addr);

`ifdef S2QED_FETCH_SYNC_TIMEOUT_EN
    logic timer_expired;

    s2qed_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (16)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_IDLE),
        .en      ((state_q == ST_WAIT_PEER) && !peer_req),
        .expired (timer_expired)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmp_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (both_req) begin
                    cmp_now = 1'b1;
                    state_d = ST_FETCH;
                end else if (bus.cpu0_req || bus.cpu1_req) begin
                    state_d = ST_WAIT_PEER;
                end
            end
            ST_WAIT_PEER: begin
                if (peer_req) begin
                    cmp_now = 1'b1;
                    state_d = ST_FETCH;
                end
`ifdef S2QED_FETCH_SYNC_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
`endif
            end
            ST_FETCH: begin
                if (bus.inst_in_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.inst_in_ready = 1'b0;
        bus.cpu0_ack      = 1'b0;
        bus.cpu1_ack      = 1'b0;
        bus.cpu0_data     = '0;
        bus.cpu1_data     = '0;
        if (state_q == ST_FETCH) begin
            bus.inst_in_ready = 1'b1;
        end
        if (state_q == ST_RESP) begin
            bus.cpu0_ack  = 1'b1;
            bus.cpu1_ack  = 1'b1;
            bus.cpu0_data = inst_q;
            bus.cpu1_data = inst_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q        <= '0;
            sync_inst     <= '0;
            fetch_cnt     <= '0;
            addr_mismatch <= 1'b0;
            waiter_q      <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && (bus.cpu0_req != bus.cpu1_req)) begin
                waiter_q <= bus.cpu1_req;
            end
            if (cmp_now && addr_ne) begin
                addr_mismatch <= 1'b1;
            end
            if ((state_q == ST_FETCH) && bus.inst_in_valid) begin
                inst_q <= bus.inst_in;
            end
            if (state_q == ST_RESP) begin
                sync_inst <= inst_q;
                if (fetch_cnt != '1) begin
                    fetch_cnt <= fetch_cnt + 1'b1;
                end
            end
        end
    end

`ifdef S2QED_FETCH_SYNC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if ((state_q == ST_WAIT_PEER) && (state_d == ST_ERROR)) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2qed_fetch_sync.sv
// Self-checking bench for s2qed_fetch_sync: directed vector table, random
// fetches against a latency/flag model, reset and timeout sequences.
module tb_s2qed_fetch_sync;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sync_inst;
    logic [1:0]  fetch_cnt;
    logic        addr_mismatch;
    logic        timeout_err;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    s2qed_fetch_sync_if bus ();

    s2qed_fetch_sync #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .sync_inst     (sync_inst),
        .fetch_cnt     (fetch_cnt),
        .addr_mismatch (addr_mismatch),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          k;
        bit          first1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] w;
        int          d;
        int          lat;
        int          cnt;
        bit          mm;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_inputs();
        bus.cpu0_req      = 1'b0;
        bus.cpu1_req      = 1'b0;
        bus.cpu0_addr     = '0;
        bus.cpu1_addr     = '0;
        bus.inst_in       = '0;
        bus.inst_in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, {bus.cpu0_ack, bus.cpu1_ack}, 0);
        check({tag, "_ready"}, bus.inst_in_ready, 0);
        check({tag, "_data"}, {bus.cpu0_data, bus.cpu1_data}, 0);
        check({tag, "_sync_inst"}, sync_inst, 0);
        check({tag, "_fetch_cnt"}, fetch_cnt, 0);
        check({tag, "_flags"}, {addr_mismatch, timeout_err}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    // One lockstep fetch: first request at the starting negedge, the peer k
    // cycles later, inst_in_valid raised d cycles after the peer request.
    task automatic run_fetch(input int k, input bit first1, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [31:0] w, input int d,
                             input int exp_lat, input int exp_cnt, input bit exp_mm);
        int c_first;
        int c_second;
        int c_valid;
        int got;
        bit acked;
        acked = 1'b0;
        got = -1;
        @(negedge clk);
        c_first  = cyc;
        c_second = c_first + k;
        c_valid  = c_second + d;
        bus.cpu0_addr = a0;
        bus.cpu1_addr = a1;
        bus.inst_in   = w;
        for (int i = 0; i < 60; i++) begin
            if (cyc == c_first) begin
                if (first1) bus.cpu1_req = 1'b1;
                else        bus.cpu0_req = 1'b1;
            end
            if (cyc == c_second) begin
                bus.cpu0_req = 1'b1;
                bus.cpu1_req = 1'b1;
            end
            if (cyc == c_valid) bus.inst_in_valid = 1'b1;
            if (bus.cpu0_ack || bus.cpu1_ack) begin
                acked = 1'b1;
                got = cyc - c_first;
                break;
            end
            check("ready_window", bus.inst_in_ready,
                  (cyc > c_second) && (cyc < c_first + exp_lat));
            check("data_idle", {bus.cpu0_data, bus.cpu1_data}, 0);
            @(negedge clk);
        end
        if (!acked) begin
            check("ack_never_arrived", 0, 1);
        end else begin
            check("ack_latency", got, exp_lat);
            check("ack_pair", {bus.cpu0_ack, bus.cpu1_ack}, 2'b11);
            check("cpu0_data", bus.cpu0_data, w);
            check("cpu1_data", bus.cpu1_data, w);
        end
        bus.cpu0_req      = 1'b0;
        bus.cpu1_req      = 1'b0;
        bus.inst_in_valid = 1'b0;
        @(negedge clk);
        check("ack_not_repeated", {bus.cpu0_ack, bus.cpu1_ack}, 0);
        check("data_after_resp", {bus.cpu0_data, bus.cpu1_data}, 0);
        check("sync_inst", sync_inst, w);
        check("fetch_cnt", fetch_cnt, exp_cnt);
        check("addr_mismatch", addr_mismatch, exp_mm);
        check("timeout_err_clean", timeout_err, 0);
    endtask

    initial begin
        int          cnt_m;
        bit          mm_m;
        int          k;
        int          d;
        bit          f1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] w;
        int          c;

        tbl[0] = '{k: 0, first1: 0, a0: 32'h0,  a1: 32'h0,  w: 32'h00500093, d: 0, lat: 2, cnt: 1, mm: 0};
        tbl[1] = '{k: 3, first1: 0, a0: 32'h4,  a1: 32'h4,  w: 32'h00100113, d: 0, lat: 5, cnt: 2, mm: 0};
        tbl[2] = '{k: 0, first1: 0, a0: 32'h8,  a1: 32'hC,  w: 32'h002081b3, d: 0, lat: 2, cnt: 3, mm: 1};
        tbl[3] = '{k: 1, first1: 1, a0: 32'h10, a1: 32'h10, w: 32'h00418233, d: 0, lat: 3, cnt: 3, mm: 1};
        tbl[4] = '{k: 0, first1: 0, a0: 32'h14, a1: 32'h14, w: 32'h40520333, d: 4, lat: 5, cnt: 3, mm: 1};
        tbl[5] = '{k: 2, first1: 1, a0: 32'h18, a1: 32'h18, w: 32'hdeadbeef, d: 2, lat: 5, cnt: 3, mm: 1};

        clear_inputs();
        @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_fetch(tbl[i].k, tbl[i].first1, tbl[i].a0, tbl[i].a1, tbl[i].w,
                      tbl[i].d, tbl[i].lat, tbl[i].cnt, tbl[i].mm);
        end

        // Reset while in FETCH: no ack for the aborted fetch, state back to zero.
        @(negedge clk);
        bus.cpu0_addr = 32'h40;
        bus.cpu1_addr = 32'h40;
        bus.inst_in   = 32'h11111111;
        bus.cpu0_req  = 1'b1;
        bus.cpu1_req  = 1'b1;
        @(negedge clk);
        check("mid_fetch_ready", bus.inst_in_ready, 1);
        #2;
        rst = 1'b1;
        bus.cpu0_req = 1'b0;
        bus.cpu1_req = 1'b0;
        bus.inst_in_valid = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.inst_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_after_abort", {bus.cpu0_ack, bus.cpu1_ack, bus.inst_in_ready}, 0);
        end
        run_fetch(0, 0, 32'h0, 32'h0, 32'h00500093, 0, 2, 1, 0);

`ifdef S2QED_FETCH_SYNC_TIMEOUT_EN
        do_reset();
        @(negedge clk);
        c = cyc;
        bus.cpu1_addr = 32'h20;
        bus.cpu1_req  = 1'b1;
        for (int i = 0; i < 8 && cyc < c + 5; i++) begin
            @(negedge clk);
            if (cyc == c + TIMEOUT) check("timeout_not_yet", timeout_err, 0);
        end
        check("timeout_err_set", timeout_err, 1);
        bus.cpu0_addr     = 32'h20;
        bus.cpu0_req      = 1'b1;
        bus.inst_in       = 32'hcafef00d;
        bus.inst_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("error_absorbing", {bus.cpu0_ack, bus.cpu1_ack, bus.inst_in_ready, timeout_err}, 1);
        end
`else
        do_reset();
        c = cyc;
        run_fetch(10, 1, 32'h24, 32'h24, 32'h0badf00d, 0, 12, 1, 0);
        check("long_wait_cycles", cyc - c >= 12, 1);
`endif

        do_reset();
        cnt_m = 0;
        mm_m  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            k  = $urandom_range(0, TIMEOUT - 1);
            d  = $urandom_range(0, 4);
            f1 = 1'($urandom_range(0, 1));
            a0 = $urandom & 32'hFFFF_FFFC;
            a1 = ($urandom_range(0, 7) == 0) ? (a0 ^ 32'h4) : a0;
            w  = $urandom;
            mm_m  = mm_m | (a0 != a1);
            cnt_m = (cnt_m >= CNT_MAX) ? CNT_MAX : cnt_m + 1;
            run_fetch(k, f1, a0, a1, w, d, k + ((d > 1) ? d : 1) + 1, cnt_m, mm_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d/%0d)", n_pass, n_total);
        $fatal(1);
    end

endmodule
